// File: rtl/regs_pkg.sv
// Shared types and constants for the 8080 register-file writeback scheduler.
package regs_pkg;

  // Byte register indices as seen by the register file.
  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_M = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  // Register-pair codes; the pair code is the index of its high byte.
  localparam logic [2:0] RP_BC = 3'd0;
  localparam logic [2:0] RP_DE = 3'd2;
  localparam logic [2:0] RP_HL = 3'd4;
  localparam logic [2:0] RP_MA = 3'd6;

  // Number of register-file write ports fed by the output stage.
  localparam int NUM_PORTS = 4;

  // One queued write request.
  typedef struct packed {
    logic        pair;
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_req_t;

  // One register-file write port as driven by the output stage.
  typedef struct packed {
    logic       wen;
    logic [2:0] addr;
    logic [7:0] data;
  } wb_port_t;

  // High-byte register of the pair containing addr (bit0 ignored).
  function automatic logic [2:0] pair_hi(input logic [2:0] addr);
    return {addr[2:1], 1'b0};
  endfunction

  // Low-byte register of the pair containing addr (bit0 ignored).
  function automatic logic [2:0] pair_lo(input logic [2:0] addr);
    return {addr[2:1], 1'b1};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Request queue for regs_wb: one push and up to two pops per cycle.
// Entries are exposed in age order (index 0 = head/oldest) with a valid
// vector, so the top can map the two oldest and scan all for hazards.
module wb_fifo
  import regs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_req_t                push_data_i,
  input  logic [1:0]             pop_n_i,
  output logic [$clog2(DEPTH):0] count_o,
  output wb_req_t                ent_o   [DEPTH],
  output logic [DEPTH-1:0]       valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = head_q + PTR_W'(pop_n_i);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_n_i);
    if (push_i) begin
      mem_d[tail_q] = push_data_i;
      tail_d        = tail_q + PTR_W'(1);
    end
  end

  // Control state: pointers and count reset so the queue starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry only has meaning while count covers it, so stale data is harmless.
    mem_q <= mem_d;
  end

  // Present entries oldest-first and flag which ones are occupied.
  always_comb begin
    valid_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_o[k]   = mem_q[head_q + PTR_W'(k)];
      valid_o[k] = (CNT_W'(k) < count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/regs_wb.sv
// Writeback scheduler for the 8080 byte register file (B,C,D,E,H,L,M,A).
// Queues byte and pair write requests and drains up to two per cycle onto
// the four register-file write ports; publishes a pending scoreboard.
// Optional feature: define REGS_WB_FWD_EN to add the fwd_addr/fwd_hit/
// fwd_data forwarding lookup.
module regs_wb
  import regs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DRAIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_pair,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        wen0,
  output logic        wen1,
  output logic        wen2,
  output logic        wen3,
  output logic [2:0]  waddr0,
  output logic [2:0]  waddr1,
  output logic [2:0]  waddr2,
  output logic [2:0]  waddr3,
  output logic [7:0]  wdata0,
  output logic [7:0]  wdata1,
  output logic [7:0]  wdata2,
  output logic [7:0]  wdata3,
  output logic [7:0]  pending,
`ifdef REGS_WB_FWD_EN
  input  logic [2:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [7:0]  fwd_data,
`endif
  output logic        empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rst_done_q, rst_done_d;
  logic [CNT_W-1:0] count_w;
  wb_req_t          ent_w [DEPTH];
  logic [DEPTH-1:0] valid_w;
  logic             push_w;
  logic [1:0]       pop_n_w;
  wb_req_t          push_req_w;
  wb_port_t         out_q [NUM_PORTS];
  wb_port_t         out_d [NUM_PORTS];

  // Ready is held low through reset and for the first edge after release.
  assign rst_done_d = 1'b1;
  assign req_ready  = rst_done_q & (count_w < CNT_W'(DEPTH));
  assign push_w     = req_valid & req_ready;
  assign push_req_w = '{pair: req_pair, addr: req_addr, data: req_data};
  assign pop_n_w    = (count_w >= CNT_W'(DRAIN)) ? 2'(DRAIN) : count_w[1:0];

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_w),
    .push_data_i (push_req_w),
    .pop_n_i     (pop_n_w),
    .count_o     (count_w),
    .ent_o       (ent_w),
    .valid_o     (valid_w)
  );

  // Map the popped entries onto ports; oldest entry takes the lowest pair.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_d[p] = '0;
    end
    for (int k = 0; k < DRAIN; k++) begin
      if (2'(k) < pop_n_w) begin
        if (ent_w[k].pair) begin
          out_d[2*k]   = '{wen: 1'b1, addr: pair_hi(ent_w[k].addr), data: ent_w[k].data[15:8]};
          out_d[2*k+1] = '{wen: 1'b1, addr: pair_lo(ent_w[k].addr), data: ent_w[k].data[7:0]};
        end else begin
          out_d[2*k]   = '{wen: 1'b1, addr: ent_w[k].addr, data: ent_w[k].data[7:0]};
        end
      end
    end
  end

  // Output stage refreshes every edge; async reset kills any half-presented pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= '0;
      end
    end else begin
      rst_done_q <= rst_done_d;
      out_q      <= out_d;
    end
  end

  assign wen0   = out_q[0].wen;
  assign wen1   = out_q[1].wen;
  assign wen2   = out_q[2].wen;
  assign wen3   = out_q[3].wen;
  assign waddr0 = out_q[0].addr;
  assign waddr1 = out_q[1].addr;
  assign waddr2 = out_q[2].addr;
  assign waddr3 = out_q[3].addr;
  assign wdata0 = out_q[0].data;
  assign wdata1 = out_q[1].data;
  assign wdata2 = out_q[2].data;
  assign wdata3 = out_q[3].data;

  // Scoreboard: any queued or presented write marks its target register.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_w[k]) begin
        if (ent_w[k].pair) begin
          pending[pair_hi(ent_w[k].addr)] = 1'b1;
          pending[pair_lo(ent_w[k].addr)] = 1'b1;
        end else begin
          pending[ent_w[k].addr] = 1'b1;
        end
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_q[p].wen) begin
        pending[out_q[p].addr] = 1'b1;
      end
    end
  end

  assign empty = (count_w == '0) & ~(wen0 | wen1 | wen2 | wen3);

`ifdef REGS_WB_FWD_EN
  // Forwarding: scan oldest to youngest (ports 0..3, then queue head..tail); last hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_q[p].wen && (out_q[p].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = out_q[p].data;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_w[k]) begin
        if (ent_w[k].pair) begin
          if (ent_w[k].addr[2:1] == fwd_addr[2:1]) begin
            fwd_hit  = 1'b1;
            fwd_data = fwd_addr[0] ? ent_w[k].data[7:0] : ent_w[k].data[15:8];
          end
        end else if (ent_w[k].addr == fwd_addr) begin
          fwd_hit  = 1'b1;
          fwd_data = ent_w[k].data[7:0];
        end
      end
    end
  end
`endif

endmodule
